mcast_input_queue: RTL and testbench

Per-port input stage of the multicast mesh router. It buffers incoming flits and tracks packet boundaries. For each header flit at the head of the queue, it drives destination list, valid mask and current routing to the lookahead routing stage. On dequeue it rewrites the header's routing field with the returned next-hop direction. It sits between the link receiver and the switch allocator/crossbar of each router input port.

---
 rtl/mcast_input_queue_if.sv | 67 ++++++
 rtl/mcast_input_queue.sv | 200 ++++++++++++++++++++
 tb/tb_mcast_input_queue.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcast_input_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : noc (package), mcast_input_queue_if (interface)
//  Description : Shared mesh types and the handshake bundle of the multicast
//                input queue.
//                noc::xy_t         - mesh coordinate {x, y}, 4 bits each
//                noc::direction_t  - one-hot output direction (5 bits)
//                Interface bundle:
//                  in_valid/in_ready/in_data      link receiver side
//                  la_destination/la_val/
//                  la_current_routing             to lookahead routing
//                  la_next_routing                from lookahead routing
//                  out_valid/out_ready/out_data/
//                  out_routing                    switch allocator / crossbar
//                Modport slave is the queue's view, master the surroundings.
//  Revision    : 1.0 - initial release
// ============================================================================
package noc;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } xy_t;

    typedef logic [4:0] direction_t;

    localparam direction_t c_GO_LOCAL = 5'b00001;
    localparam direction_t c_GO_EAST  = 5'b00010;
    localparam direction_t c_GO_WEST  = 5'b00100;
    localparam direction_t c_GO_NORTH = 5'b01000;
    localparam direction_t c_GO_SOUTH = 5'b10000;

endpackage

interface mcast_input_queue_if #(
    parameter int FLIT_WIDTH = 64,
    parameter int DEST_SIZE  = 6
);

    logic                          in_valid;
    logic                          in_ready;
    logic [FLIT_WIDTH-1:0]         in_data;

    noc::xy_t [0:DEST_SIZE-1]      la_destination;
    logic [DEST_SIZE-1:0]          la_val;
    noc::direction_t               la_current_routing;
    noc::direction_t               la_next_routing;

    logic                          out_valid;
    logic                          out_ready;
    logic [FLIT_WIDTH-1:0]         out_data;
    noc::direction_t               out_routing;

    modport slave (
        input  in_valid, in_data, la_next_routing, out_ready,
        output in_ready, la_destination, la_val, la_current_routing,
               out_valid, out_data, out_routing
    );

    modport master (
        output in_valid, in_data, la_next_routing, out_ready,
        input  in_ready, la_destination, la_val, la_current_routing,
               out_valid, out_data, out_routing
    );

endinterface
`default_nettype wire

// File: rtl/mcast_input_queue.sv
`default_nettype none
// ============================================================================
//  Module      : mcast_input_queue
//  Description : Per-port input stage of the multicast mesh router. Buffers
//                flits in a circular FIFO, tracks packet boundaries, presents
//                the head header's destination list to the lookahead routing
//                stage and rewrites the header's routing field with the
//                returned next-hop direction on the way out.
//  Ports       : clk        - clock
//                rst        - synchronous active-high reset
//                bus        - mcast_input_queue_if.slave (in_*, la_*, out_*)
//                proto_err  - sticky protocol error, cleared only by rst
//  Flit layout : [W-1] header, [W-2] tail, [W-3:W-7] routing, then DEST_SIZE
//                slots of {val, xy} packed downward from bit W-8.
//  Options     : MCAST_QUEUE_BYPASS_EN - when defined, an incoming flit
//                reaches out_* in the same cycle if the queue is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module mcast_input_queue #(
    parameter int DEPTH      = 4,
    parameter int DEST_SIZE  = 6,
    parameter int FLIT_WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    mcast_input_queue_if.slave bus,
    output logic               proto_err
);

    localparam int c_XY_W     = $bits(noc::xy_t);
    localparam int c_SLOT_W   = 1 + c_XY_W;
    localparam int c_PTR_W    = $clog2(DEPTH);
    localparam int c_CNT_W    = c_PTR_W + 1;
    localparam int c_HDR_BIT  = FLIT_WIDTH - 1;
    localparam int c_TAIL_BIT = FLIT_WIDTH - 2;
    localparam int c_RT_HI    = FLIT_WIDTH - 3;
    localparam int c_RT_LO    = FLIT_WIDTH - 7;
    localparam int c_DEST_TOP = FLIT_WIDTH - 8;

    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PKT  = 1'b1
    } state_t;

    // Storage and state
    logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_CNT_W-1:0]    r_count;
    state_t                r_state;
    noc::direction_t       r_pkt_routing;
    logic                  r_proto_err;

    // Combinational
    state_t                   w_state_next;
    logic                     w_bypass;
    logic                     w_in_ready;
    logic                     w_head_avail;
    logic [FLIT_WIDTH-1:0]    w_head_flit;
    logic                     w_is_hdr;
    logic                     w_is_tail;
    noc::direction_t          w_head_rt;
    logic                     w_la_hdr;
    noc::xy_t [0:DEST_SIZE-1] w_dest_dec;
    logic [DEST_SIZE-1:0]     w_val_dec;
    logic                     w_out_valid;
    logic [FLIT_WIDTH-1:0]    w_out_data;
    noc::direction_t          w_out_routing;
    logic                     w_drop;
    logic                     w_err;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_pop_mem;
    logic                     w_write;

`ifdef MCAST_QUEUE_BYPASS_EN
    // An empty queue presents the incoming flit directly at its head.
    assign w_bypass = (r_count == '0) && bus.in_valid && !rst;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_in_ready   = !rst && (r_count != c_FULL);
    assign w_head_avail = (r_count != '0) || w_bypass;
    assign w_head_flit  = w_bypass ? bus.in_data : r_mem[r_rd_ptr];
    assign w_is_hdr     = w_head_flit[c_HDR_BIT];
    assign w_is_tail    = w_head_flit[c_TAIL_BIT];
    assign w_head_rt    = w_head_flit[c_RT_HI:c_RT_LO];

    // Destination slot i: val bit, then its xy just below it.
    for (genvar i = 0; i < DEST_SIZE; i++) begin : g_dest
        assign w_val_dec[i]  = w_head_flit[c_DEST_TOP - i*c_SLOT_W];
        assign w_dest_dec[i] = w_head_flit[c_DEST_TOP - i*c_SLOT_W - 1 -: c_XY_W];
    end

    assign w_la_hdr = w_head_avail && w_is_hdr;

    // Packet FSM: next state and head-of-queue outputs
    always_comb begin
        w_state_next  = r_state;
        w_out_valid   = 1'b0;
        w_out_data    = '0;
        w_out_routing = '0;
        w_drop        = 1'b0;
        w_err         = 1'b0;
        if (w_head_avail) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_hdr) begin
                        w_out_valid                  = 1'b1;
                        w_out_data                   = w_head_flit;
                        w_out_data[c_RT_HI:c_RT_LO]  = bus.la_next_routing;
                        w_out_routing                = w_head_rt;
                        if (bus.out_ready && !w_is_tail) begin
                            w_state_next = S_PKT;
                        end
                    end else begin
                        // Orphan body/tail: discarded without being offered.
                        w_drop = 1'b1;
                        w_err  = 1'b1;
                    end
                end
                S_PKT: begin
                    w_out_valid   = 1'b1;
                    w_out_data    = w_head_flit;
                    w_out_routing = r_pkt_routing;
                    if (w_is_hdr) begin
                        // Stray header inside a packet travels as plain body.
                        w_err = 1'b1;
                    end else if (bus.out_ready && w_is_tail) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign w_push    = bus.in_valid && w_in_ready;
    assign w_pop     = (w_out_valid && bus.out_ready) || w_drop;
    // A bypassed flit consumed in the same cycle never touches storage.
    assign w_pop_mem = w_pop && !w_bypass;
    assign w_write   = w_push && !(w_bypass && w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_pkt_routing <= '0;
            r_proto_err   <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop_mem) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_write, w_pop_mem})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_pop && (r_state == S_IDLE) && w_is_hdr && !w_is_tail) begin
                r_pkt_routing <= w_head_rt;
            end
            if (w_err) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // Flit storage carries no reset; outputs are gated by the occupancy.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    assign bus.in_ready           = w_in_ready;
    assign bus.out_valid          = w_out_valid;
    assign bus.out_data           = w_out_data;
    assign bus.out_routing        = w_out_routing;
    assign bus.la_destination     = w_la_hdr ? w_dest_dec : '0;
    assign bus.la_val             = w_la_hdr ? w_val_dec : '0;
    assign bus.la_current_routing = w_la_hdr ? w_head_rt : '0;
    assign proto_err              = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_mcast_input_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcast_input_queue
//  Description : Directed self-checking bench for mcast_input_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mcast_input_queue;

    localparam int W     = 64;
    localparam int DS    = 6;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic proto_err;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mcast_input_queue_if #(.FLIT_WIDTH(W), .DEST_SIZE(DS)) bus ();

    mcast_input_queue #(
        .DEPTH(DEPTH), .DEST_SIZE(DS), .FLIT_WIDTH(W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .proto_err(proto_err)
    );

    function automatic logic [W-1:0] hdr(input logic tail, input logic [4:0] rt,
                                         input logic [3:0] x, input logic [3:0] y);
        logic [W-1:0] f;
        f = '0;
        f[63] = 1'b1; f[62] = tail; f[61:57] = rt;
        f[56] = 1'b1; f[55:52] = x; f[51:48] = y;
        return f;
    endfunction

    function automatic logic [W-1:0] body(input logic tail, input logic [15:0] pl);
        logic [W-1:0] f;
        f = '0;
        f[62] = tail; f[15:0] = pl;
        return f;
    endfunction

    function automatic logic [W-1:0] rewr(input logic [W-1:0] f, input logic [4:0] nr);
        logic [W-1:0] g;
        g = f;
        g[61:57] = nr;
        return g;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0;
        bus.out_ready = 1'b0; bus.la_next_routing = '0;
        tick; tick;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_during: got %b want 0", bus.in_ready); end
        rst = 1'b0; #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready_after: got %b want 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
        n_checks++; if (bus.out_routing !== 5'd0 || bus.la_val !== 6'd0 || bus.la_current_routing !== 5'd0) begin
            n_fail++; $display("FAIL rst_routing_la: got rt=%b val=%b cur=%b want 0", bus.out_routing, bus.la_val, bus.la_current_routing); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rst_proto_err: got %b want 0", proto_err); end
    endtask

    task automatic test_single_flit;
        logic [W-1:0] f;
        f = hdr(1'b1, noc::c_GO_EAST, 4'd2, 4'd1);
        bus.la_next_routing = noc::c_GO_NORTH;
        bus.in_valid = 1'b1; bus.in_data = f; bus.out_ready = 1'b0;
        #1;
`ifndef MCAST_QUEUE_BYPASS_EN
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL sf_latency: got out_valid=%b want 0", bus.out_valid); end
`endif
        tick;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL sf_valid: got %b want 1", bus.out_valid); end
        n_checks++; if (bus.out_routing !== noc::c_GO_EAST) begin n_fail++; $display("FAIL sf_out_routing: got %b want %b", bus.out_routing, noc::c_GO_EAST); end
        n_checks++; if (bus.out_data !== rewr(f, noc::c_GO_NORTH)) begin n_fail++; $display("FAIL sf_out_data: got %h want %h", bus.out_data, rewr(f, noc::c_GO_NORTH)); end
        n_checks++; if (bus.la_destination[0] !== 8'h21 || bus.la_val !== 6'b000001 || bus.la_current_routing !== noc::c_GO_EAST) begin
            n_fail++; $display("FAIL sf_la: got dest0=%h val=%b cur=%b want 21 000001 %b", bus.la_destination[0], bus.la_val, bus.la_current_routing, noc::c_GO_EAST); end
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0 || dut.r_state !== 1'b0) begin
            n_fail++; $display("FAIL sf_after_pop: got valid=%b state=%0d want 0 0", bus.out_valid, dut.r_state); end
    endtask

    task automatic test_packet;
        logic [W-1:0] p [4];
        logic [W-1:0] e;
        int k;
        p[0] = hdr(1'b0, noc::c_GO_WEST, 4'd3, 4'd4);
        p[1] = body(1'b0, 16'hB001);
        p[2] = body(1'b0, 16'hB002);
        p[3] = body(1'b1, 16'hB003);
        bus.la_next_routing = noc::c_GO_SOUTH;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_data = p[i];
            tick;
        end
        bus.in_valid = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 16 && k < 4; cyc++) begin
            bus.out_ready = (cyc % 2 == 0);
            e = (k == 0) ? rewr(p[0], noc::c_GO_SOUTH) : p[k];
            #1;
            n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
                n_fail++; $display("FAIL pkt_flit%0d: got v=%b %h want v=1 %h", k, bus.out_valid, bus.out_data, e); end
            n_checks++; if (bus.out_routing !== noc::c_GO_WEST) begin
                n_fail++; $display("FAIL pkt_routing%0d: got %b want %b", k, bus.out_routing, noc::c_GO_WEST); end
            tick;
            if (bus.out_ready) k++;
        end
        bus.out_ready = 1'b0;
        n_checks++; if (k != 4) begin n_fail++; $display("FAIL pkt_timeout: got %0d flits want 4", k); end
        n_checks++; if (bus.out_valid !== 1'b0 || dut.r_state !== 1'b0) begin
            n_fail++; $display("FAIL pkt_end: got valid=%b state=%0d want 0 0", bus.out_valid, dut.r_state); end
    endtask

    task automatic test_fill_wrap;
        logic [W-1:0] exp_q [$];
        logic [W-1:0] f;
        logic [4:0]   dirs [4];
        int sent;
        dirs[0] = noc::c_GO_EAST; dirs[1] = noc::c_GO_WEST;
        dirs[2] = noc::c_GO_NORTH; dirs[3] = noc::c_GO_SOUTH;
        bus.la_next_routing = noc::c_GO_LOCAL;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            f = hdr(1'b1, dirs[i], 4'(i), 4'h0);
            bus.in_valid = 1'b1; bus.in_data = f;
            #1;
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready%0d: got %b want 1", i, bus.in_ready); end
            exp_q.push_back(f);
            tick;
        end
        // Offered fifth flit must be refused.
        bus.in_data = hdr(1'b1, noc::c_GO_EAST, 4'hF, 4'hF);
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: got in_ready=%b want 0", bus.in_ready); end
        tick;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        n_checks++; if (bus.out_data !== rewr(exp_q[0], noc::c_GO_LOCAL)) begin
            n_fail++; $display("FAIL fill_head: got %h want %h", bus.out_data, rewr(exp_q[0], noc::c_GO_LOCAL)); end
        void'(exp_q.pop_front());
        tick;
        bus.out_ready = 1'b0;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_after_pop: got %b want 1", bus.in_ready); end
        sent = 0;
        for (int cyc = 0; cyc < 40 && (sent < 8 || exp_q.size() > 0); cyc++) begin
            bus.out_ready = 1'b1;
            bus.in_valid  = (sent < 8);
            bus.in_data   = hdr(1'b1, dirs[sent % 4], 4'(sent + 4), 4'hA);
            #1;
            if (bus.out_valid === 1'b1 && exp_q.size() > 0) begin
                n_checks++; if (bus.out_data !== rewr(exp_q[0], noc::c_GO_LOCAL) || bus.out_routing !== exp_q[0][61:57]) begin
                    n_fail++; $display("FAIL wrap_order: got %h rt=%b want %h rt=%b", bus.out_data, bus.out_routing, rewr(exp_q[0], noc::c_GO_LOCAL), exp_q[0][61:57]); end
                void'(exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(bus.in_data);
                sent++;
            end
            tick;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        n_checks++; if (sent != 8 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL wrap_timeout: got sent=%0d left=%0d want 8 0", sent, exp_q.size()); end
    endtask

    task automatic test_orphan_body;
        logic [W-1:0] f;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = body(1'b0, 16'hDEAD);
        tick;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL orphan_valid: got %b want 0", bus.out_valid); end
        tick;
        n_checks++; if (bus.out_valid !== 1'b0 || proto_err !== 1'b1 || dut.r_count !== 3'd0) begin
            n_fail++; $display("FAIL orphan_drop: got valid=%b err=%b count=%0d want 0 1 0", bus.out_valid, proto_err, dut.r_count); end
        f = hdr(1'b1, noc::c_GO_NORTH, 4'd5, 4'd5);
        bus.la_next_routing = noc::c_GO_EAST;
        bus.in_valid = 1'b1; bus.in_data = f;
        tick;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== rewr(f, noc::c_GO_EAST)) begin
            n_fail++; $display("FAIL orphan_next_hdr: got v=%b %h want v=1 %h", bus.out_valid, bus.out_data, rewr(f, noc::c_GO_EAST)); end
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL orphan_sticky: got %b want 1", proto_err); end
    endtask

    task automatic test_reset_mid_packet;
        logic [W-1:0] f;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = hdr(1'b0, noc::c_GO_EAST, 4'd1, 4'd1);
        tick;
        bus.in_data = body(1'b0, 16'h1234);
        tick;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        n_checks++; if (dut.r_state !== 1'b1) begin n_fail++; $display("FAIL mid_in_pkt: got state=%0d want 1", dut.r_state); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0", bus.in_ready); end
        tick;
        rst = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_routing !== 5'd0 || bus.la_val !== 6'd0 || bus.la_current_routing !== 5'd0) begin
            n_fail++; $display("FAIL mid_outputs: got v=%b d=%h rt=%b val=%b want all 0", bus.out_valid, bus.out_data, bus.out_routing, bus.la_val); end
        n_checks++; if (dut.r_count !== 3'd0 || dut.r_state !== 1'b0 || proto_err !== 1'b0) begin
            n_fail++; $display("FAIL mid_state: got count=%0d state=%0d err=%b want 0 0 0", dut.r_count, dut.r_state, proto_err); end
        f = hdr(1'b1, noc::c_GO_WEST, 4'd7, 4'd7);
        bus.la_next_routing = noc::c_GO_LOCAL;
        bus.in_valid = 1'b1; bus.in_data = f;
        tick;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== rewr(f, noc::c_GO_LOCAL) || bus.out_routing !== noc::c_GO_WEST) begin
            n_fail++; $display("FAIL mid_new_hdr: got v=%b %h rt=%b want v=1 %h %b", bus.out_valid, bus.out_data, bus.out_routing, rewr(f, noc::c_GO_LOCAL), noc::c_GO_WEST); end
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        n_checks++; if (proto_err !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_clean: got err=%b valid=%b want 0 0", proto_err, bus.out_valid); end
    endtask

    task automatic test_bypass;
        logic [W-1:0] f;
        f = hdr(1'b1, noc::c_GO_SOUTH, 4'd9, 4'd3);
        bus.la_next_routing = noc::c_GO_WEST;
        bus.in_valid = 1'b1; bus.in_data = f; bus.out_ready = 1'b1;
        #1;
`ifdef MCAST_QUEUE_BYPASS_EN
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== rewr(f, noc::c_GO_WEST)) begin
            n_fail++; $display("FAIL byp_same_cycle: got v=%b %h want v=1 %h", bus.out_valid, bus.out_data, rewr(f, noc::c_GO_WEST)); end
        tick;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        n_checks++; if (dut.r_count !== 3'd0 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL byp_count: got count=%0d valid=%b want 0 0", dut.r_count, bus.out_valid); end
`else
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL byp_off_latency: got %b want 0", bus.out_valid); end
        tick;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== rewr(f, noc::c_GO_WEST)) begin
            n_fail++; $display("FAIL byp_off_next: got v=%b %h want v=1 %h", bus.out_valid, bus.out_data, rewr(f, noc::c_GO_WEST)); end
        tick;
        bus.out_ready = 1'b0;
        n_checks++; if (dut.r_count !== 3'd0 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL byp_off_drain: got count=%0d valid=%b want 0 0", dut.r_count, bus.out_valid); end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single_flit;
        test_packet;
        test_fill_wrap;
        test_orphan_body;
        test_reset_mid_packet;
        test_bypass;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
